// File: rtl/gfp8_nv_dot_accum.sv
// GFP8 native-vector dot-product engine: per-group block dot sums, exponent-aligned
// NV partials, and a saturating K-dimension accumulator closed by i_last.
module gfp8_nv_dot_accum #(
    parameter int GROUPS     = 4,
    parameter int GROUP_SIZE = 32,
    parameter int MAN_W      = 8,
    parameter int EXP_BIAS   = 15,
    parameter int ACC_W      = 32
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic                                i_valid,
    input  logic                                i_last,
    input  logic [8*GROUPS-1:0]                 i_exp_left,
    input  logic [GROUPS*GROUP_SIZE*MAN_W-1:0]  i_man_left,
    input  logic [8*GROUPS-1:0]                 i_exp_right,
    input  logic [GROUPS*GROUP_SIZE*MAN_W-1:0]  i_man_right,
    output logic                                o_valid,
    output logic [ACC_W-1:0]                    o_result_mantissa,
    output logic [7:0]                          o_result_exponent,
    output logic [15:0]                         o_nv_count,
    output logic                                o_overflow
);

    localparam int PROD_W = 2*MAN_W;
    localparam int SUM_W  = PROD_W + $clog2(GROUP_SIZE);
    localparam int P_W    = SUM_W + $clog2(GROUPS);

    // Arithmetic right shift that floors; shifts past the width give pure sign fill.
    function automatic logic signed [ACC_W-1:0] shr_acc(input logic signed [ACC_W-1:0] v,
                                                        input logic [7:0] sh);
        if (32'(sh) >= ACC_W) return {ACC_W{v[ACC_W-1]}};
        return v >>> sh;
    endfunction

    // Stage 1: operand registers
    logic                               s1_valid, s1_last;
    logic [8*GROUPS-1:0]                s1_exp_l, s1_exp_r;
    logic [GROUPS*GROUP_SIZE*MAN_W-1:0] s1_man_l, s1_man_r;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_exp_l <= '0;
            s1_exp_r <= '0;
            s1_man_l <= '0;
            s1_man_r <= '0;
        end else begin
            s1_valid <= i_valid;
            s1_last  <= i_valid & i_last;
            if (i_valid) begin
                s1_exp_l <= i_exp_left;
                s1_exp_r <= i_exp_right;
                s1_man_l <= i_man_left;
                s1_man_r <= i_man_right;
            end
        end
    end

    // Stage 2: per-group dot sums and unbiased exponents
    logic signed [SUM_W-1:0]  s2_sum_d [GROUPS];
    logic signed [7:0]        s2_exp_d [GROUPS];
    logic signed [SUM_W-1:0]  s2_sum   [GROUPS];
    logic signed [7:0]        s2_exp   [GROUPS];
    logic                     s2_valid, s2_last;
    logic signed [MAN_W-1:0]  ml, mr;
    logic signed [PROD_W-1:0] prod;

    always_comb begin
        ml   = '0;
        mr   = '0;
        prod = '0;
        for (int unsigned g = 0; g < GROUPS; g++) begin
            s2_sum_d[g] = '0;
            for (int unsigned e = 0; e < GROUP_SIZE; e++) begin
                ml   = s1_man_l[(g*GROUP_SIZE+e)*MAN_W +: MAN_W];
                mr   = s1_man_r[(g*GROUP_SIZE+e)*MAN_W +: MAN_W];
                prod = PROD_W'(ml) * PROD_W'(mr);
                s2_sum_d[g] = s2_sum_d[g] + SUM_W'(prod);
            end
            s2_exp_d[g] = 8'(int'(s1_exp_l[g*8 +: 5]) + int'(s1_exp_r[g*8 +: 5]) - 2*EXP_BIAS);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            for (int unsigned g = 0; g < GROUPS; g++) begin
                s2_sum[g] <= '0;
                s2_exp[g] <= '0;
            end
        end else begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            for (int unsigned g = 0; g < GROUPS; g++) begin
                s2_sum[g] <= s2_sum_d[g];
                s2_exp[g] <= s2_exp_d[g];
            end
        end
    end

    // Stage 3: align groups on the largest exponent and reduce to one NV partial
    logic signed [7:0]       emax;
    logic signed [ACC_W-1:0] p_sum;
    logic signed [P_W-1:0]   s3_p;
    logic signed [7:0]       s3_emax;
    logic                    s3_valid, s3_last;

    always_comb begin
        emax = s2_exp[0];
        for (int unsigned g = 1; g < GROUPS; g++)
            if (s2_exp[g] > emax) emax = s2_exp[g];
        p_sum = '0;
        for (int unsigned g = 0; g < GROUPS; g++)
            p_sum = p_sum + shr_acc(ACC_W'(s2_sum[g]), 8'(emax - s2_exp[g]));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s3_valid <= 1'b0;
            s3_last  <= 1'b0;
            s3_p     <= '0;
            s3_emax  <= '0;
        end else begin
            s3_valid <= s2_valid;
            s3_last  <= s2_last;
            s3_p     <= P_W'(p_sum);
            s3_emax  <= emax;
        end
    end

    // Stage 4: exponent-aligned saturating accumulation
    logic signed [ACC_W-1:0] acc, acc_d, a_al, p_al, p_ext;
    logic signed [7:0]       acc_exp, acc_exp_d;
    logic [15:0]             cnt, cnt_d;
    logic                    ovf, ovf_d, first, s4_fire;
    logic [ACC_W:0]          sum;

    always_comb begin
        p_ext     = ACC_W'(s3_p);
        a_al      = acc;
        p_al      = p_ext;
        sum       = '0;
        acc_d     = p_ext;
        acc_exp_d = s3_emax;
        cnt_d     = 16'd1;
        ovf_d     = 1'b0;
        if (!first) begin
            if (acc_exp >= s3_emax) begin
                acc_exp_d = acc_exp;
                p_al      = shr_acc(p_ext, 8'(acc_exp - s3_emax));
            end else begin
                a_al      = shr_acc(acc, 8'(s3_emax - acc_exp));
            end
            sum   = {a_al[ACC_W-1], a_al} + {p_al[ACC_W-1], p_al};
            acc_d = sum[ACC_W-1:0];
            ovf_d = ovf;
            if (sum[ACC_W] != sum[ACC_W-1]) begin
                acc_d = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
                ovf_d = 1'b1;
            end
            cnt_d = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
        end
    end

    // Closing beat re-arms via 'first'; outputs copy the held accumulator one edge later.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            acc     <= '0;
            acc_exp <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            first   <= 1'b1;
            s4_fire <= 1'b0;
        end else begin
            s4_fire <= s3_valid & s3_last;
            if (s3_valid) begin
                acc     <= acc_d;
                acc_exp <= acc_exp_d;
                cnt     <= cnt_d;
                ovf     <= ovf_d;
                first   <= s3_last;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid           <= 1'b0;
            o_result_mantissa <= '0;
            o_result_exponent <= '0;
            o_nv_count        <= '0;
            o_overflow        <= 1'b0;
        end else begin
            o_valid <= s4_fire;
            if (s4_fire) begin
                o_result_mantissa <= acc;
                o_result_exponent <= acc_exp;
                o_nv_count        <= cnt;
                o_overflow        <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_gfp8_nv_dot_accum.sv
// Directed bench for gfp8_nv_dot_accum: expected results queued at stimulus time,
// checked with immediate assertions when o_valid pulses.
module tb_gfp8_nv_dot_accum;

    localparam int GROUPS = 4, GROUP_SIZE = 32, MAN_W = 8, ACC_W = 32;

    logic                               i_clk = 1'b0;
    logic                               i_reset, i_valid, i_last;
    logic [8*GROUPS-1:0]                i_exp_left, i_exp_right;
    logic [GROUPS*GROUP_SIZE*MAN_W-1:0] i_man_left, i_man_right;
    logic                               o_valid, o_overflow;
    logic [ACC_W-1:0]                   o_result_mantissa;
    logic [7:0]                         o_result_exponent;
    logic [15:0]                        o_nv_count;

    gfp8_nv_dot_accum #(.GROUPS(GROUPS), .GROUP_SIZE(GROUP_SIZE), .MAN_W(MAN_W),
                        .EXP_BIAS(15), .ACC_W(ACC_W)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_last(i_last),
        .i_exp_left(i_exp_left), .i_man_left(i_man_left),
        .i_exp_right(i_exp_right), .i_man_right(i_man_right),
        .o_valid(o_valid), .o_result_mantissa(o_result_mantissa),
        .o_result_exponent(o_result_exponent), .o_nv_count(o_nv_count),
        .o_overflow(o_overflow)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        string       tag;
        logic [31:0] m;
        logic [7:0]  e;
        logic [15:0] n;
        logic        ov;
        int          at;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Every group g gets mantissa byte g of ml_g/mr_g in all its elements.
    task automatic beat(input logic [31:0] el, input logic [31:0] er,
                        input logic [31:0] ml_g, input logic [31:0] mr_g, input logic last);
        @(negedge i_clk);
        for (int g = 0; g < GROUPS; g++)
            for (int e = 0; e < GROUP_SIZE; e++) begin
                i_man_left [(g*GROUP_SIZE+e)*MAN_W +: MAN_W] = ml_g[g*8 +: 8];
                i_man_right[(g*GROUP_SIZE+e)*MAN_W +: MAN_W] = mr_g[g*8 +: 8];
            end
        i_exp_left  = el;
        i_exp_right = er;
        i_valid     = 1'b1;
        i_last      = last;
    endtask

    // Called right after the closing beat: output is due 4 edges after it is sampled.
    task automatic expect_res(input string tag, input logic [31:0] m, input logic [7:0] e,
                              input logic [15:0] n, input logic ov);
        exp_t x;
        x.tag = tag; x.m = m; x.e = e; x.n = n; x.ov = ov; x.at = cyc + 5;
        exp_q.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            i_valid = 1'b0;
            i_last  = 1'b0;
        end
    endtask

    task automatic check_zero(input string tag);
        tests++;
        assert (o_valid === 1'b0 && o_result_mantissa === '0 && o_result_exponent === '0 &&
                o_nv_count === '0 && o_overflow === 1'b0)
        else begin
            fails++;
            $error("FAIL %s: got v=%b m=%0d e=%0d n=%0d ov=%b, want all zero", tag, o_valid,
                   o_result_mantissa, o_result_exponent, o_nv_count, o_overflow);
        end
    endtask

    always @(negedge i_clk) begin
        if (o_valid) begin
            tests++;
            assert (exp_q.size() > 0)
            else begin
                fails++;
                $error("FAIL unexpected_valid: got o_valid=1 at cycle %0d, want no pulse", cyc);
            end
            if (exp_q.size() > 0) begin
                exp_t x;
                x = exp_q.pop_front();
                tests++;
                assert (o_result_mantissa === x.m && o_result_exponent === x.e &&
                        o_nv_count === x.n && o_overflow === x.ov && cyc === x.at)
                else begin
                    fails++;
                    $error("FAIL %s: got m=%0d e=%0d n=%0d ov=%b cyc=%0d, want m=%0d e=%0d n=%0d ov=%b cyc=%0d",
                           x.tag, $signed(o_result_mantissa), $signed(o_result_exponent),
                           o_nv_count, o_overflow, cyc, $signed(x.m), $signed(x.e), x.n, x.ov, x.at);
                end
            end
        end
    end

    localparam logic [31:0] E15 = {4{8'd15}};
    localparam logic [31:0] ONE = 32'h01010101;
    localparam logic [31:0] NEG = 32'hFFFFFFFF;

    initial begin
        i_reset = 1'b1; i_valid = 1'b0; i_last = 1'b0;
        i_exp_left = '0; i_exp_right = '0; i_man_left = '0; i_man_right = '0;
        @(negedge i_clk);
        @(negedge i_clk);
        check_zero("reset_state");
        i_reset = 1'b0;

        // exponent bytes carry junk in [7:5] that must be ignored
        beat({4{8'hEF}}, {4{8'h2F}}, ONE, ONE, 1'b1);
        expect_res("single_nv", 32'd128, 8'd0, 16'd1, 1'b0);
        idle(8);
        tests++;
        assert (o_valid === 1'b0 && o_result_mantissa === 32'd128 && o_nv_count === 16'd1)
        else begin
            fails++;
            $error("FAIL hold: got v=%b m=%0d n=%0d, want v=0 m=128 n=1",
                   o_valid, o_result_mantissa, o_nv_count);
        end

        beat({8'd15, 8'd14, 8'd16, 8'd15}, {8'd15, 8'd14, 8'd16, 8'd15}, ONE, ONE, 1'b1);
        expect_res("group_align", 32'd50, 8'd2, 16'd1, 1'b0);
        idle(6);

        beat({4{8'd16}}, {4{8'd16}}, ONE, ONE, 1'b0);
        beat(E15, E15, ONE, ONE, 1'b1);
        expect_res("two_nv", 32'd160, 8'd2, 16'd2, 1'b0);
        idle(6);

        beat(E15, E15, ONE, ONE, 1'b1);
        expect_res("b2b_pos", 32'd128, 8'd0, 16'd1, 1'b0);
        beat(E15, E15, NEG, ONE, 1'b1);
        expect_res("b2b_neg", 32'hFFFFFF80, 8'd0, 16'd1, 1'b0);
        beat(E15, E15, '0, ONE, 1'b1);
        expect_res("b2b_zero", 32'd0, 8'd0, 16'd1, 1'b0);
        idle(6);

        // group 0 (E=-30, S=-32) shifted by 62 collapses to -1 against group 1 (E=32, S=32)
        beat({8'd0, 8'd0, 8'd31, 8'd0}, {8'd0, 8'd0, 8'd31, 8'd0},
             32'h000001FF, 32'h00000101, 1'b1);
        expect_res("group_signfill", 32'd31, 8'd32, 16'd1, 1'b0);
        idle(6);

        // bubbles inside a sequence; second term sign-fills to -1 in the accumulator
        beat({4{8'd31}}, {4{8'd31}}, ONE, ONE, 1'b0);
        idle(3);
        beat('0, '0, NEG, ONE, 1'b1);
        expect_res("acc_signfill_bubble", 32'd127, 8'd32, 16'd2, 1'b0);
        idle(6);

        for (int i = 0; i < 1024; i++)
            beat(E15, E15, 32'h80808080, 32'h80808080, i == 1023);
        expect_res("saturate", 32'h7FFFFFFF, 8'd0, 16'd1024, 1'b1);
        beat(E15, E15, ONE, ONE, 1'b1);
        expect_res("ovf_rearm", 32'd128, 8'd0, 16'd1, 1'b0);
        idle(6);

        for (int i = 0; i < 3; i++)
            beat(E15, E15, ONE, ONE, 1'b0);
        beat(E15, E15, ONE, ONE, 1'b1);
        i_reset = 1'b1;
        @(negedge i_clk);
        check_zero("mid_seq_reset");
        i_reset = 1'b0;
        i_valid = 1'b0;
        i_last  = 1'b0;
        idle(6);
        check_zero("reset_drops_inflight");
        beat(E15, E15, ONE, ONE, 1'b1);
        expect_res("after_reset", 32'd128, 8'd0, 16'd1, 1'b0);
        idle(2);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++)
            @(negedge i_clk);
        idle(2);
        tests++;
        assert (exp_q.size() === 0)
        else begin
            fails++;
            $error("FAIL drain: got %0d results outstanding, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gfp8_nv_dot_accum.md
# gfp8_nv_dot_accum

Parametrised, fully pipelined GFP8 native-vector (NV) dot-product engine with K-dimension accumulation. Each input beat carries one NV (GROUPS groups of GROUP_SIZE signed 8-bit mantissas plus one 5-bit biased exponent per group, per operand). The block computes the block-floating-point dot product of each NV pair and accumulates successive NVs, aligned on exponent, until a beat marked last. It then emits one mantissa/exponent result. It sits between the GEMM tile buffers and the result writeback path, and replaces single-NV, non-accumulating dot units.

## Interface
- GROUPS, 4: groups per NV.
- GROUP_SIZE, 32: elements per group.
- MAN_W, 8: signed mantissa width.
- EXP_BIAS, 15: exponent bias per operand.
- ACC_W, 32: accumulator and result mantissa width, signed.

- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- i_valid  in  1  NV beat present; accepted every cycle, no backpressure.
- i_last  in  1  qualifies i_valid; beat closes the current accumulation sequence.
- i_exp_left  in  8*GROUPS  byte g is the exponent for group g; bits [4:0] are used and bits [7:5] are ignored.
- i_man_left  in  GROUPS*GROUP_SIZE*MAN_W  element e of group g is at [(g*GROUP_SIZE+e)*MAN_W +: MAN_W].
- i_exp_right, i_man_right  in  same widths  right operand, same packing.
- o_valid  out  1  one-cycle pulse when a sequence result is ready.
- o_result_mantissa  out  ACC_W  signed accumulated mantissa.
- o_result_exponent  out  8  signed unbiased exponent.
- o_nv_count  out  16  number of NVs in the completed sequence; saturates at 65535.
- o_overflow  out  1  accumulator saturated at some point in the sequence.

## Operation
- Stage 1 registers the operands when i_valid is high.
- Stage 2 computes, per group g:
  - the dot sum S_g = Σ man_l*man_r (16-bit products; sum is 16+clog2(GROUP_SIZE) bits, signed);
  - the exponent E_g = expL[4:0]+expR[4:0]-2*EXP_BIAS (range -30..32, 8-bit signed).
- Stage 3 forms the NV partial:
  - Emax = max E_g;
  - P = Σ (S_g >>> (Emax-E_g)), an arithmetic shift that floors. Any shift of at least the operand width yields the sign fill (0 or -1).
  - P width: group-sum width + clog2(GROUPS).
- Stage 4 accumulates into accumulator A (ACC_W bits) with exponent EA:
  - The first beat of a sequence (after reset or after a last beat) loads A=P and EA=Emax, then sets count=1.
  - Otherwise it aligns to E=max(EA,Emax). The smaller-exponent term is arithmetically right-shifted by the difference, using the same floor and sign-fill rules. Then A = sat(A_aligned+P_aligned), EA=E, and count increments.
  - sat clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and sets a sticky overflow bit for the sequence. The clamped value continues to accumulate.
- On the last beat the stage-4 result is copied to the output registers and o_valid pulses. The accumulator, count and sticky overflow are then re-armed for a new sequence.
- Back-to-back sequences are supported, including single-NV sequences on consecutive cycles.
- A beat with i_valid low is a bubble and does not disturb accumulation state.

## Timing
- A beat sampled at edge N (i_valid=1, i_last=1) produces o_valid=1 after edge N+4. The pulse is exactly one cycle wide.
- Throughput is one NV per cycle.
- o_result_*, o_nv_count and o_overflow hold their values between pulses.
- Reset values: o_valid=0, o_result_mantissa=0, o_result_exponent=0, o_nv_count=0, o_overflow=0. All pipeline valids are cleared, and the accumulator and count are zeroed.
- Reset mid-sequence drops all in-flight beats and the partial accumulation. The first valid beat after reset starts a new sequence.
- i_valid during a reset cycle is ignored.
- If i_last arrives on the first beat, the output is that NV's partial alone, with o_nv_count=1.

## Test plan
- Single NV, all mantissas 1, all exponents 15, i_last=1 -> after 4 cycles o_valid=1, mantissa=128, exponent=0, count=1, overflow=0.
- Single NV, all mantissas 1, group exponents {15,16,14,15} for G0..G3 on both operands -> mantissa=50 (32+8+8+2), exponent=2.
- Two-NV sequence: NV0 has all exponents 16, NV1 has all exponents 15, all mantissas 1, last on NV1 -> one o_valid with mantissa=160 (128 + 128>>>2), exponent=2, count=2. There is no o_valid after NV0.
- Consecutive single-NV sequences on 3 cycles (mantissas 1, -1, 0; exponents 15) -> three consecutive o_valid pulses with mantissa 128, -128, 0.
- 1024 NVs with all mantissas -128 and exponents 15, last on the final beat -> mantissa=2147483647, overflow=1, count=1024. The next single-NV sequence shows overflow=0.
- Assert i_reset after 3 NVs of an open sequence, then send one NV (all 1s, exponent 15, last) -> no o_valid from the dropped beats, outputs read 0 during reset, and the result is 128 with count=1.
